// File: rtl/iwdg_wb_master.sv
// iwdg_wb_master: Wishbone initiator that boots the IWDG and refreshes it.
// Define IWDG_MASTER_LOCK_EN to hold lok_m2s across the boot sequence.
module iwdg_wb_master #(
    parameter int unsigned GRL         = 1,
    parameter logic [31:0] BASE_ADR    = 32'h0100_0000,
    parameter logic [2:0]  PR_VAL      = 3'd4,
    parameter logic [11:0] RLR_VAL     = 12'hFFF,
    parameter logic [15:0] KICK_PERIOD = 16'd1000,
    parameter logic [7:0]  ACK_TIMEOUT = 8'd16,
    parameter logic [1:0]  RETRY_MAX   = 2'd3,
    parameter logic [7:0]  POLL_MAX    = 8'd255
) (
    input  logic         clk_m2s,
    input  logic         rst_m2s,
    input  logic         start,
    input  logic         kick_en,
    output logic [31:0]  dat_m2s,
    output logic [31:0]  adr_m2s,
    output logic [GRL:0] sel_m2s,
    output logic         cyc_m2s,
    output logic         stb_m2s,
    output logic         we_m2s,
    output logic         lok_m2s,
    input  logic [31:0]  dat_s2m,
    input  logic         ack_s2m,
    input  logic         err_s2m,
    input  logic         rty_s2m,
    output logic         busy,
    output logic         running,
    output logic         fault
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_UNLOCK,
        S_WR_PR,
        S_WR_RLR,
        S_POLL_ST,
        S_START,
        S_RUN,
        S_KICK,
        S_FAULT
    } state_t;

    state_t      state_q, state_d, nxt_ok;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [1:0]  rty_q, rty_d;
    logic [7:0]  poll_q, poll_d;
    logic [15:0] kick_q, kick_d;
    logic        bus_st;
    logic        req_we;
    logic [31:0] req_adr;
    logic [31:0] req_dat;
    logic        term;
    logic        st_busy;
    logic        unused_st_bits;

    assign unused_st_bits = ^dat_s2m[31:2];

    // Per-state transfer descriptor and successor on normal completion
    always_comb begin
        bus_st  = 1'b0;
        req_adr = BASE_ADR;
        req_dat = '0;
        req_we  = 1'b1;
        nxt_ok  = state_q;
        unique case (state_q)
            S_UNLOCK: begin
                bus_st  = 1'b1;
                req_dat = 32'h0000_5555;
                nxt_ok  = S_WR_PR;
            end
            S_WR_PR: begin
                bus_st  = 1'b1;
                req_adr = BASE_ADR + 32'h4;
                req_dat = {29'd0, PR_VAL};
                nxt_ok  = S_WR_RLR;
            end
            S_WR_RLR: begin
                bus_st  = 1'b1;
                req_adr = BASE_ADR + 32'h8;
                req_dat = {20'd0, RLR_VAL};
                nxt_ok  = S_POLL_ST;
            end
            S_POLL_ST: begin
                bus_st  = 1'b1;
                req_adr = BASE_ADR + 32'hC;
                req_we  = 1'b0;
                nxt_ok  = S_START;
            end
            S_START: begin
                bus_st  = 1'b1;
                req_dat = 32'h0000_CCCC;
                nxt_ok  = S_RUN;
            end
            S_KICK: begin
                bus_st  = 1'b1;
                req_dat = 32'h0000_AAAA;
                nxt_ok  = S_RUN;
            end
            default: ;
        endcase
    end

    assign term = ack_s2m | err_s2m | rty_s2m;

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        tmo_d   = tmo_q;
        rty_d   = rty_q;
        poll_d  = poll_q;
        kick_d  = kick_q;
        if (state_q == S_IDLE && start) begin
            state_d = S_UNLOCK;
        end
        if (state_q == S_RUN && kick_en) begin
            if (kick_q == KICK_PERIOD - 16'd1) begin
                state_d = S_KICK;
                kick_d  = '0;
            end else begin
                kick_d = kick_q + 16'd1;
            end
        end
        // cyc low for one cycle after every termination gives the idle gap
        if (bus_st) begin
            if (!cyc_q) begin
                cyc_d = 1'b1;
                tmo_d = '0;
                we_d  = req_we;
                adr_d = req_adr;
                dat_d = req_dat;
            end else if (term || tmo_q == ACK_TIMEOUT - 8'd1) begin
                cyc_d = 1'b0;
                we_d  = 1'b0;
                adr_d = '0;
                dat_d = '0;
                if (err_s2m) begin
                    state_d = S_FAULT;
                end else if (rty_s2m) begin
                    if (rty_q == RETRY_MAX) state_d = S_FAULT;
                    else rty_d = rty_q + 2'd1;
                end else if (ack_s2m) begin
                    rty_d = '0;
                    if (state_q == S_POLL_ST && dat_s2m[1:0] != 2'b00) begin
                        if (poll_q == POLL_MAX - 8'd1) state_d = S_FAULT;
                        else poll_d = poll_q + 8'd1;
                    end else begin
                        state_d = nxt_ok;
                    end
                end else begin
                    state_d = S_FAULT;
                end
            end else begin
                tmo_d = tmo_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_m2s) begin
        if (rst_m2s) begin
            state_q <= S_IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            tmo_q   <= '0;
            rty_q   <= '0;
            poll_q  <= '0;
            kick_q  <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            tmo_q   <= tmo_d;
            rty_q   <= rty_d;
            poll_q  <= poll_d;
            kick_q  <= kick_d;
        end
    end

`ifdef IWDG_MASTER_LOCK_EN
    logic lok_q;
    logic boot_d;

    assign boot_d = state_d inside {S_UNLOCK, S_WR_PR, S_WR_RLR,
                                    S_POLL_ST, S_START};

    // Rises with the first UNLOCK strobe, falls when START terminates
    always_ff @(posedge clk_m2s) begin
        if (rst_m2s) lok_q <= 1'b0;
        else lok_q <= boot_d && (cyc_d || lok_q);
    end

    assign lok_m2s = lok_q;
`else
    assign lok_m2s = 1'b0;
`endif

    assign st_busy = !(state_q inside {S_IDLE, S_RUN, S_FAULT});

    assign cyc_m2s = cyc_q;
    assign stb_m2s = cyc_q;
    assign we_m2s  = we_q;
    assign adr_m2s = adr_q;
    assign dat_m2s = dat_q;
    assign sel_m2s = {(GRL + 1){cyc_q}};
    assign busy    = st_busy;
    assign running = (state_q == S_RUN) || (state_q == S_KICK);
    assign fault   = (state_q == S_FAULT);

endmodule

// File: tb/tb_iwdg_wb_master.sv
// tb_iwdg_wb_master: scripted Wishbone slave plus a transfer-level model
// of the boot sequence; checks transfers, flags and refresh timing.
`timescale 1ns/1ps
module tb_iwdg_wb_master;

    localparam int          KP   = 20;
    localparam int          TMO  = 16;
    localparam int          RMAX = 3;
    localparam int          PMAX = 255;
    localparam logic [31:0] BASE = 32'h0100_0000;
`ifdef IWDG_MASTER_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        kick_en = 1'b0;
    logic [31:0] dat_m2s, adr_m2s;
    logic [31:0] dat_s2m = '0;
    logic [1:0]  sel;
    logic        cyc, stb, we, lok, busy, running, fault;
    logic        ack = 1'b0, err = 1'b0, rty = 1'b0;

    iwdg_wb_master #(
        .KICK_PERIOD(16'(KP))
    ) dut (
        .clk_m2s(clk),
        .rst_m2s(rst),
        .start(start),
        .kick_en(kick_en),
        .dat_m2s(dat_m2s),
        .adr_m2s(adr_m2s),
        .sel_m2s(sel),
        .cyc_m2s(cyc),
        .stb_m2s(stb),
        .we_m2s(we),
        .lok_m2s(lok),
        .dat_s2m(dat_s2m),
        .ack_s2m(ack),
        .err_s2m(err),
        .rty_s2m(rty),
        .busy(busy),
        .running(running),
        .fault(fault)
    );

    always #5 clk = ~clk;

    typedef enum int {R_ACK, R_RTY, R_ERR} kind_t;
    typedef struct {
        kind_t       kind;
        int          delay;
        logic [31:0] rdata;
    } rsp_t;
    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        logic        lok;
        int          t;
    } xfer_t;
    typedef struct {
        string name;
        int    stage;
        int    nrty;
        int    delay;
        bit    err;
        int    npoll;
        bit    xf;
        int    xn;
    } vec_t;

    rsp_t  scr_q[$];
    rsp_t  slv_q[$];
    xfer_t log_q[$];
    xfer_t exp_q[$];
    bit    exp_fault;
    int    tests = 0;
    int    fails = 0;
    int    unstable = 0;
    int    ncyc = 0;

    // Scripted slave: one script entry per transfer attempt
    bit    active = 0;
    bit    responded = 0;
    int    wcnt = 0;
    rsp_t  cur;
    xfer_t first;

    always @(posedge clk) ncyc <= ncyc + 1;

    always @(negedge clk) begin
        ack = 1'b0;
        err = 1'b0;
        rty = 1'b0;
        dat_s2m = '0;
        if (cyc) begin
            if (!active) begin
                active = 1;
                responded = 0;
                wcnt = 0;
                if (slv_q.size() > 0) cur = slv_q.pop_front();
                else cur = '{R_ACK, 0, 32'h0};
                first = '{adr_m2s, dat_m2s, we, lok, ncyc};
                log_q.push_back(first);
            end else if (responded || adr_m2s != first.adr ||
                         dat_m2s != first.dat || we != first.we ||
                         lok != first.lok) begin
                unstable++;
            end
            if (!stb || sel != 2'b11) unstable++;
            if (!responded && wcnt == cur.delay) begin
                responded = 1;
                case (cur.kind)
                    R_ACK: begin
                        ack = 1'b1;
                        dat_s2m = cur.rdata;
                    end
                    R_RTY: rty = 1'b1;
                    default: err = 1'b1;
                endcase
            end
            wcnt++;
        end else begin
            active = 0;
            if (stb) unstable++;
        end
    end

    function automatic xfer_t op_x(input int op);
        xfer_t x;
        x.t = 0;
        x.lok = LOCK;
        x.we = 1'b1;
        x.adr = BASE;
        x.dat = 32'h0000_CCCC;
        case (op)
            0: x.dat = 32'h0000_5555;
            1: begin x.adr = BASE + 32'h4; x.dat = 32'h4; end
            2: begin x.adr = BASE + 32'h8; x.dat = 32'hFFF; end
            3: begin x.adr = BASE + 32'hC; x.dat = 32'h0; x.we = 1'b0; end
            default: ;
        endcase
        return x;
    endfunction

    // Walk the five boot operations consuming one script entry per attempt
    task automatic run_model();
        rsp_t s[$];
        rsp_t r;
        int   nr, np;
        bit   done;
        s = scr_q;
        exp_q.delete();
        exp_fault = 0;
        for (int op = 0; op < 5 && !exp_fault; op++) begin
            nr = 0;
            np = 0;
            done = 0;
            while (!done && !exp_fault) begin
                if (s.size() > 0) r = s.pop_front();
                else r = '{R_ACK, 0, 32'h0};
                exp_q.push_back(op_x(op));
                if (r.delay >= TMO || r.kind == R_ERR) begin
                    exp_fault = 1;
                end else if (r.kind == R_RTY) begin
                    nr++;
                    if (nr > RMAX) exp_fault = 1;
                end else if (op == 3 && r.rdata[1:0] != 2'b00) begin
                    nr = 0;
                    np++;
                    if (np >= PMAX) exp_fault = 1;
                end else begin
                    done = 1;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        kick_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic build_script(input int stage, input int nrty,
                                input int delay, input bit e,
                                input int npoll);
        scr_q.delete();
        for (int op = 0; op < 5; op++) begin
            if (op == stage) begin
                repeat (nrty) scr_q.push_back('{R_RTY, 0, 32'h0});
                if (op == 3) repeat (npoll) scr_q.push_back('{R_ACK, 0, 32'h1});
                if (e) scr_q.push_back('{R_ERR, 0, 32'h0});
                else scr_q.push_back('{R_ACK, delay, 32'h0});
            end else begin
                scr_q.push_back('{R_ACK, 0, 32'h0});
            end
        end
    endtask

    task automatic run_scenario(input string name, input bit has_exp,
                                input bit xf, input int xn);
        int n, k;
        bit ok;
        run_model();
        do_reset();
        slv_q = scr_q;
        log_q.delete();
        unstable = 0;
        pulse_start();
        k = 0;
        while (!running && !fault && k < 5000) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (k >= 5000) begin
            fails++;
            $display("FAIL %s boot_end: still busy after %0d cycles", name, k);
        end
        pulse_start();
        repeat (20) @(negedge clk);
        if (has_exp) begin
            check({name, " fault_tbl"}, fault, xf);
            check({name, " nxfer_tbl"}, log_q.size(), xn);
        end
        check({name, " fault"}, fault, exp_fault);
        check({name, " running"}, running, !exp_fault);
        check({name, " busy"}, busy, 0);
        check({name, " nxfer"}, log_q.size(), exp_q.size());
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        ok = 1;
        tests++;
        for (int i = 0; i < n && ok; i++) begin
            if (log_q[i].adr !== exp_q[i].adr || log_q[i].dat !== exp_q[i].dat ||
                log_q[i].we !== exp_q[i].we || log_q[i].lok !== exp_q[i].lok) begin
                ok = 0;
                fails++;
                $display("FAIL %s xfer[%0d]: got adr=%h dat=%h we=%b lok=%b required adr=%h dat=%h we=%b lok=%b",
                         name, i, log_q[i].adr, log_q[i].dat, log_q[i].we, log_q[i].lok,
                         exp_q[i].adr, exp_q[i].dat, exp_q[i].we, exp_q[i].lok);
            end
        end
        check({name, " stable"}, unstable, 0);
    endtask

    task automatic wait_log(input int n, input string name);
        int k;
        k = 0;
        while (log_q.size() < n && k < 1000) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (k >= 1000) begin
            fails++;
            $display("FAIL %s wait: got %0d transfers required %0d", name, log_q.size(), n);
        end
    endtask

    vec_t tbl[11];
    rsp_t rr;
    int   v;

    initial begin
        tbl[0]  = '{"boot",       0, 0, 0,  0, 0,   0, 5};
        tbl[1]  = '{"pr_rty2",    1, 2, 0,  0, 0,   0, 7};
        tbl[2]  = '{"pr_rty3",    1, 3, 0,  0, 0,   0, 8};
        tbl[3]  = '{"pr_rty4",    1, 4, 0,  0, 0,   1, 5};
        tbl[4]  = '{"unlock_tmo", 0, 0, 16, 0, 0,   1, 1};
        tbl[5]  = '{"unlock_d15", 0, 0, 15, 0, 0,   0, 5};
        tbl[6]  = '{"start_err",  4, 0, 0,  1, 0,   1, 5};
        tbl[7]  = '{"poll3",      3, 0, 0,  0, 3,   0, 8};
        tbl[8]  = '{"poll254",    3, 0, 0,  0, 254, 0, 259};
        tbl[9]  = '{"poll255",    3, 0, 0,  0, 255, 1, 258};
        tbl[10] = '{"rlr_err",    2, 0, 0,  1, 0,   1, 3};

        do_reset();
        @(negedge clk);
        check("rst cyc", cyc, 0);
        check("rst stb", stb, 0);
        check("rst we_sel_lok", {we, sel, lok}, 0);
        check("rst adr", adr_m2s, 0);
        check("rst dat", dat_m2s, 0);
        check("rst flags", {busy, running, fault}, 0);

        foreach (tbl[i]) begin
            build_script(tbl[i].stage, tbl[i].nrty, tbl[i].delay,
                         tbl[i].err, tbl[i].npoll);
            run_scenario(tbl[i].name, 1'b1, tbl[i].xf, tbl[i].xn);
        end

        for (int r = 0; r < 25; r++) begin
            scr_q.delete();
            for (int j = 0; j < 30; j++) begin
                v = $urandom_range(0, 99);
                rr.kind = (v < 75) ? R_ACK : (v < 95) ? R_RTY : R_ERR;
                rr.delay = ($urandom_range(0, 31) == 0) ? 16 : $urandom_range(0, 4);
                rr.rdata = $urandom;
                if ($urandom_range(0, 2) != 0) rr.rdata[1:0] = 2'b00;
                scr_q.push_back(rr);
            end
            run_scenario($sformatf("rand%0d", r), 1'b0, 1'b0, 0);
        end

        // Periodic refresh and kick_en freeze
        do_reset();
        slv_q.delete();
        log_q.delete();
        unstable = 0;
        kick_en = 1'b1;
        pulse_start();
        wait_log(8, "kick");
        if (log_q.size() >= 8) begin
            check("kick adr", log_q[5].adr, BASE);
            check("kick dat", log_q[6].dat, 32'h0000_AAAA);
            check("kick we_lok", {log_q[7].we, log_q[7].lok}, 2'b10);
            check("kick first gap", log_q[5].t - log_q[4].t, KP + 2);
            check("kick period", log_q[6].t - log_q[5].t, KP + 2);
            check("kick period2", log_q[7].t - log_q[6].t, KP + 2);
        end
        repeat (5) @(negedge clk);
        kick_en = 1'b0;
        repeat (30) @(negedge clk);
        check("freeze no kick", log_q.size(), 8);
        kick_en = 1'b1;
        wait_log(9, "kick_resume");
        if (log_q.size() >= 9)
            check("kick frozen period", log_q[8].t - log_q[7].t, KP + 2 + 30);
        check("kick run flags", {running, busy, fault, lok}, 4'b1000);
        check("kick stable", unstable, 0);

        // Reset in the middle of the RLR write
        build_script(2, 0, 10, 0, 0);
        do_reset();
        slv_q = scr_q;
        log_q.delete();
        pulse_start();
        wait_log(3, "rlr");
        repeat (3) @(negedge clk);
        check("rlr mid busy_cyc", {busy, cyc}, 2'b11);
        check("rlr mid lok", lok, LOCK);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rlr rst cyc_stb", {cyc, stb}, 2'b00);
        check("rlr rst flags", {busy, running, fault, lok}, 4'b0000);
        check("rlr rst adr", adr_m2s, 0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
